sram_wr_port_arb: RTL and testbench
===================================

# sram_wr_port_arb

Parametrised write-port front end for one single-port SRAM bank in the NTT datapath. It generalises the fixed 16-to-1 write-channel mux to N_CH channels. It adds a round-robin arbitration mode beside direct select, registers the SRAM-side outputs, returns per-channel grants and counts committed writes. It sits between the butterfly/PE write sources and the SRAM macro pins (CEN/WEN active-low).

## Interface
- N_CH, 16: number of write channels (2..64).
- MA_W, `MA_width: SRAM address width.
- D_W, `D_width: SRAM data width.
- SEL_W, $clog2(N_CH)+1: sel_in width (derived; the extra bit encodes "no channel").
- Reset is asynchronous and active-high; the block uses a single clock.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- mode  in  1  0 = direct select, 1 = round-robin.
- w_enable  in  1  global write enable, both modes.
- sel_in  in  SEL_W  channel index, direct mode only.
- req  in  N_CH  per-channel write request, round-robin mode only.
- A_in  in  N_CH*MA_W  channel addresses, channel k at [k*MA_W +: MA_W].
- D_in  in  N_CH*D_W  channel data, channel k at [k*D_W +: D_W].
- wr_cnt_clr  in  1  synchronous clear of wr_cnt.
- gnt  out  N_CH  one-hot grant, combinational, same cycle as request.
- CEN_out  out  1  SRAM chip enable, active-low, registered.
- WEN_out  out  1  SRAM write enable, active-low, registered.
- A_out  out  MA_W  SRAM address, registered.
- D_out  out  D_W  SRAM write data, registered.
- wr_cnt  out  16  committed-write counter, saturating.

## Operation
- **Issue decision.** Each cycle the block either issues a write for one channel k or stays idle. An issue for k means gnt[k]=1, and at the next edge CEN_out=0, WEN_out=0, A_out=A_in[k], D_out=D_in[k]. Idle means gnt=0, and at the next edge CEN_out=1, WEN_out=1, A_out=0, D_out=0.
- **Direct mode (mode=0).**
  - Issue for k=sel_in when w_enable=1 and sel_in<N_CH.
  - Idle when sel_in≥N_CH or w_enable=0.
  - req is ignored.
- **Round-robin mode (mode=1).**
  - When w_enable=1 and req≠0, grant the first set req bit at or after ptr, searching upward and wrapping from N_CH-1 to 0.
  - Idle when req=0 or w_enable=0.
  - sel_in is ignored.
- **ptr.**
  - ptr is a log2(N_CH)-bit register.
  - On every issue in either mode, ptr ← (k+1) mod N_CH.
  - ptr is unchanged when idle and is preserved across mode changes.
- **wr_cnt.**
  - +1 per issue, saturating at 0xFFFF.
  - wr_cnt_clr=1 forces 0 at the next edge and wins over a simultaneous issue.
- **Reset values.** CEN_out=1, WEN_out=1, A_out=0, D_out=0, wr_cnt=0, ptr=0. gnt follows its inputs combinationally, with ptr=0.
- **Mode changes.** mode may change on any cycle. The decision uses the mode value sampled that cycle, with no dead cycle.

## Timing
- Latency is one cycle from the issue decision (inputs at edge t) to the SRAM pins (valid after edge t+1).
- gnt is valid in the same cycle as its inputs, with no registered delay. A source must hold A_in/D_in only in its granted cycle.
- Throughput is one write per cycle. Back-to-back issues, including to the same channel, are allowed.
- Round-robin fairness: with all req held high, grants cycle through 0,1,…,N_CH-1,0 on consecutive cycles.
- Reset assertion mid-write forces the idle output state immediately (asynchronously). Release is synchronous to the first clk edge with rst=0.
- There are no combinational paths from inputs to CEN_out/WEN_out/A_out/D_out.

## Test plan
- **Reset.** Assert rst mid-stream with a write pending. Required: CEN_out=1, WEN_out=1, A_out=0, D_out=0, wr_cnt=0 without waiting for a clk edge. After release, the first round-robin grant with req=all-ones is channel 0.
- **Direct select sweep.** N_CH=16, mode=0, w_enable=1, sel_in=0..15 on consecutive cycles, A_in[k]=k, D_in[k]=0x100+k. Required: gnt one-hot each cycle; one cycle later A_out=k, D_out=0x100+k, CEN_out=WEN_out=0; wr_cnt=16 at the end. Then sel_in=16 gives idle outputs with A_out=D_out=0.
- **w_enable gating.** mode=0, sel_in=3, w_enable=0. Required: gnt=0, CEN_out=WEN_out=1, wr_cnt unchanged.
- **Round-robin fairness.**
  - mode=1, req=0xFFFF for 20 cycles. Required: grants 0..15 then 0..3, one per cycle.
  - Then req=0x0011 with ptr=4. Required: grants 4,0,4,0.
- **Mode switch and ptr.** A direct issue on channel 7, then mode=1 with req=0x8181. Required: next grant is channel 8, then 15, then 0.
- **Counter boundaries.**
  - Preload wr_cnt to 0xFFFE via 65534 issues. Two more issues give 0xFFFF (saturated).
  - wr_cnt_clr together with an issue gives 0 while the write still reaches the pins.

Source files
------------

// File: rtl/sram_wr_port_arb.sv
// rtl/sram_wr_port_arb.sv - N_CH-channel write-port front end for one single-port SRAM bank
//
// Selects one write channel per cycle, either directly (mode=0, sel_in) or
// round-robin among requesters (mode=1, req). The selected channel sees a
// combinational one-hot grant, and its address and data reach the SRAM pins
// one cycle later through registers. wr_cnt counts issued writes and saturates.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mode              0 = direct select, 1 = round-robin
//   w_enable          global write enable
//   sel_in            direct-mode channel index (values >= N_CH mean "none")
//   req               round-robin per-channel request
//   A_in, D_in        packed channel address/data, channel k at [k*W +: W]
//   wr_cnt_clr        synchronous clear of wr_cnt
//   gnt               one-hot grant, same cycle as the request
//   CEN_out, WEN_out  SRAM chip/write enable, active-low, registered
//   A_out, D_out      SRAM address/data, registered, zero when idle
//   wr_cnt            saturating committed-write counter

`ifndef MA_width
`define MA_width 10
`endif
`ifndef D_width
`define D_width 32
`endif

module sram_wr_port_arb #(
   parameter int N_CH  = 16,
   parameter int MA_W  = `MA_width,
   parameter int D_W   = `D_width,
   parameter int SEL_W = $clog2(N_CH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 w_enable,
   input  logic [SEL_W-1:0]     sel_in,
   input  logic [N_CH-1:0]      req,
   input  logic [N_CH*MA_W-1:0] A_in,
   input  logic [N_CH*D_W-1:0]  D_in,
   input  logic                 wr_cnt_clr,
   output logic [N_CH-1:0]      gnt,
   output logic                 CEN_out,
   output logic                 WEN_out,
   output logic [MA_W-1:0]      A_out,
   output logic [D_W-1:0]       D_out,
   output logic [15:0]          wr_cnt
);

   localparam int PTR_W = $clog2(N_CH);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] rr_idx;
   logic             rr_found;
   logic [PTR_W-1:0] k;
   logic             issue;
   logic [MA_W-1:0]  a_sel;
   logic [D_W-1:0]   d_sel;

   // Round-robin search: first set req bit at or after ptr, wrapping at N_CH
   // (N_CH need not be a power of two, so the wrap is explicit).
   always_comb begin
      int c;
      c        = 0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int i = 0; i < N_CH; i++) begin
         c = int'(ptr) + i;
         if (c >= N_CH) c = c - N_CH;
         if (!rr_found && req[c[PTR_W-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = c[PTR_W-1:0];
         end
      end
   end

   // Issue decision uses the mode sampled this cycle.
   always_comb begin
      if (mode) begin
         issue = w_enable && rr_found;
         k     = rr_idx;
      end else begin
         issue = w_enable && (sel_in < SEL_W'(N_CH));
         k     = sel_in[PTR_W-1:0];
      end
   end

   always_comb begin
      a_sel = A_in[int'(k)*MA_W +: MA_W];
      d_sel = D_in[int'(k)*D_W +: D_W];
      gnt   = issue ? (N_CH'(1) << k) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         CEN_out <= 1'b1;
         WEN_out <= 1'b1;
         A_out   <= '0;
         D_out   <= '0;
         ptr     <= '0;
         wr_cnt  <= '0;
      end else begin
         CEN_out <= ~issue;
         WEN_out <= ~issue;
         A_out   <= issue ? a_sel : '0;
         D_out   <= issue ? d_sel : '0;
         // ptr tracks the last issue in either mode so a mode switch resumes fairly.
         if (issue) ptr <= (k == PTR_W'(N_CH - 1)) ? '0 : k + 1'b1;
         if (wr_cnt_clr)
            wr_cnt <= '0;
         else if (issue && wr_cnt != 16'hFFFF)
            wr_cnt <= wr_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_sram_wr_port_arb.sv
// tb/tb_sram_wr_port_arb.sv - directed self-checking bench for sram_wr_port_arb

module tb_sram_wr_port_arb;

   localparam int N_CH  = 16;
   localparam int MA_W  = 8;
   localparam int D_W   = 16;
   localparam int SEL_W = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 mode;
   logic                 w_enable;
   logic [SEL_W-1:0]     sel_in;
   logic [N_CH-1:0]      req;
   logic [N_CH*MA_W-1:0] A_in;
   logic [N_CH*D_W-1:0]  D_in;
   logic                 wr_cnt_clr;
   logic [N_CH-1:0]      gnt;
   logic                 CEN_out;
   logic                 WEN_out;
   logic [MA_W-1:0]      A_out;
   logic [D_W-1:0]       D_out;
   logic [15:0]          wr_cnt;

   int checks   = 0;
   int failures = 0;

   sram_wr_port_arb #(.N_CH(N_CH), .MA_W(MA_W), .D_W(D_W), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .w_enable(w_enable), .sel_in(sel_in),
      .req(req), .A_in(A_in), .D_in(D_in), .wr_cnt_clr(wr_cnt_clr), .gnt(gnt),
      .CEN_out(CEN_out), .WEN_out(WEN_out), .A_out(A_out), .D_out(D_out),
      .wr_cnt(wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cen"}, 32'(CEN_out), 32'd1);
      chk({tag, "_wen"}, 32'(WEN_out), 32'd1);
      chk({tag, "_a"},   32'(A_out),   32'd0);
      chk({tag, "_d"},   32'(D_out),   32'd0);
   endtask

   task automatic chk_write(input string tag, input int ch);
      chk({tag, "_cen"}, 32'(CEN_out), 32'd0);
      chk({tag, "_wen"}, 32'(WEN_out), 32'd0);
      chk({tag, "_a"},   32'(A_out),   32'(ch));
      chk({tag, "_d"},   32'(D_out),   32'(32'h100 + ch));
   endtask

   initial begin
      for (int i = 0; i < N_CH; i++) begin
         A_in[i*MA_W +: MA_W] = MA_W'(i);
         D_in[i*D_W +: D_W]   = D_W'(16'h100 + i);
      end
      rst = 1'b1; mode = 1'b0; w_enable = 1'b0; sel_in = '0; req = '0; wr_cnt_clr = 1'b0;
      #2;
      chk_idle("reset_state");
      chk("reset_cnt", 32'(wr_cnt), 32'd0);
      chk("reset_gnt", 32'(gnt), 32'd0);

      // Release, then reset mid-stream with writes pending.
      @(negedge clk); rst = 1'b0;
      w_enable = 1'b1; sel_in = 5;
      @(negedge clk);
      chk_write("pre_rst", 5);
      chk("pre_rst_cnt", 32'(wr_cnt), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_idle("async_rst");
      chk("async_rst_cnt", 32'(wr_cnt), 32'd0);
      w_enable = 1'b0;
      @(negedge clk); rst = 1'b0;

      // Round-robin fairness after reset: 0..15 then 0..3.
      mode = 1'b1; w_enable = 1'b1; req = 16'hFFFF;
      for (int i = 0; i < 20; i++) begin
         #1 chk("rr_gnt", 32'(gnt), 32'(1) << (i % 16));
         @(negedge clk);
         chk_write("rr_out", i % 16);
      end
      req = 16'h0011;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr_sparse_gnt", 32'(gnt), (i % 2 == 0) ? 32'h10 : 32'h1);
         @(negedge clk);
      end

      // Direct select sweep from a cleared counter.
      w_enable = 1'b0; wr_cnt_clr = 1'b1;
      @(negedge clk);
      wr_cnt_clr = 1'b0;
      chk("clr_cnt", 32'(wr_cnt), 32'd0);
      mode = 1'b0; w_enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sel_in = SEL_W'(i);
         #1 chk("dir_gnt", 32'(gnt), 32'(1) << i);
         @(negedge clk);
         chk_write("dir_out", i);
      end
      chk("dir_cnt", 32'(wr_cnt), 32'd16);
      sel_in = 16;
      #1 chk("dir_none_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      chk_idle("dir_none");
      chk("dir_none_cnt", 32'(wr_cnt), 32'd16);

      // w_enable gating.
      sel_in = 3; w_enable = 1'b0;
      #1 chk("wen_gate_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      chk_idle("wen_gate");
      chk("wen_gate_cnt", 32'(wr_cnt), 32'd16);

      // Direct issue on 7, then round-robin continues from 8.
      sel_in = 7; w_enable = 1'b1;
      #1 chk("sw_dir_gnt", 32'(gnt), 32'h80);
      @(negedge clk);
      chk_write("sw_dir", 7);
      mode = 1'b1; req = 16'h8181;
      #1 chk("sw_rr0", 32'(gnt), 32'h100);
      @(negedge clk);
      chk_write("sw_rr0_out", 8);
      #1 chk("sw_rr1", 32'(gnt), 32'h8000);
      @(negedge clk);
      #1 chk("sw_rr2", 32'(gnt), 32'h1);
      @(negedge clk);

      // Counter saturation.
      w_enable = 1'b0; wr_cnt_clr = 1'b1;
      @(negedge clk);
      wr_cnt_clr = 1'b0;
      req = 16'hFFFF; w_enable = 1'b1;
      repeat (65534) @(negedge clk);
      chk("cnt_fffe", 32'(wr_cnt), 32'hFFFE);
      @(negedge clk);
      chk("cnt_ffff", 32'(wr_cnt), 32'hFFFF);
      @(negedge clk);
      chk("cnt_sat", 32'(wr_cnt), 32'hFFFF);

      // Clear wins over a simultaneous issue; the write still reaches the pins.
      mode = 1'b0; sel_in = 9; wr_cnt_clr = 1'b1;
      @(negedge clk);
      wr_cnt_clr = 1'b0; w_enable = 1'b0;
      chk("clr_issue_cnt", 32'(wr_cnt), 32'd0);
      chk_write("clr_issue", 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
